// File: rtl/acq_peak_search.sv
// Streaming peak detector: tracks the running maximum correlation magnitude over a
// search frame with its code-phase/Doppler cell, then holds a thresholded result.
module acq_peak_search #(
  parameter int DATA_WIDTH = 32,
  parameter int CODE_LEN   = 4092,
  parameter int CODE_W     = 12,
  parameter int DOPP_W     = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH:0]   i_s_axis_tdata,
  input  logic [DOPP_W-1:0]     i_s_axis_tuser,
  input  logic                  i_s_axis_tvalid,
  input  logic                  i_s_axis_tlast,
  output logic                  o_s_axis_tready,
  input  logic [DATA_WIDTH:0]   i_threshold,
  output logic [DATA_WIDTH:0]   o_peak_mag,
  output logic [CODE_W-1:0]     o_peak_code,
  output logic [DOPP_W-1:0]     o_peak_dopp,
  output logic                  o_detect,
  output logic                  o_len_err,
  output logic                  o_m_valid,
  input  logic                  i_m_ready
);

  typedef enum logic {SEARCH = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [CODE_W-1:0] LAST_CODE = CODE_W'(CODE_LEN - 1);

  state_t              r_state, w_state_nxt;
  logic                r_tready, w_tready_nxt;
  logic                r_m_valid, w_m_valid_nxt;
  logic                r_first;
  logic [CODE_W-1:0]   r_cnt;
  logic [DATA_WIDTH:0] r_peak;
  logic [CODE_W-1:0]   r_code;
  logic [DOPP_W-1:0]   r_dopp;
  logic [DATA_WIDTH:0] r_thr;
  logic                r_detect;
  logic                r_len_err;

  logic                w_acc;
  logic                w_last;
  logic                w_out_hs;
  logic                w_upd;
  logic [DATA_WIDTH:0] w_peak_new;
  logic [DATA_WIDTH:0] w_thr;

  assign w_acc      = i_s_axis_tvalid & r_tready;
  assign w_last     = w_acc & i_s_axis_tlast;
  assign w_out_hs   = r_m_valid & i_m_ready;
  // First beat loads unconditionally; afterwards strictly greater wins, so ties keep the earlier cell.
  assign w_upd      = r_first | (i_s_axis_tdata > r_peak);
  assign w_peak_new = w_upd ? i_s_axis_tdata : r_peak;
  assign w_thr      = r_first ? i_threshold : r_thr;

  always_comb begin
    w_state_nxt   = r_state;
    w_tready_nxt  = r_tready;
    w_m_valid_nxt = r_m_valid;
    case (r_state)
      SEARCH: begin
        w_tready_nxt  = 1'b1;
        w_m_valid_nxt = 1'b0;
        if (w_last) begin
          w_state_nxt   = HOLD;
          w_tready_nxt  = 1'b0;
          w_m_valid_nxt = 1'b1;
        end
      end
      HOLD: begin
        w_tready_nxt  = 1'b0;
        w_m_valid_nxt = 1'b1;
        if (i_m_ready) begin
          w_state_nxt   = SEARCH;
          w_tready_nxt  = 1'b1;
          w_m_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt   = SEARCH;
        w_tready_nxt  = 1'b0;
        w_m_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= SEARCH;
      r_tready  <= 1'b0;
      r_m_valid <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tready  <= w_tready_nxt;
      r_m_valid <= w_m_valid_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_first   <= 1'b1;
      r_cnt     <= '0;
      r_peak    <= '0;
      r_code    <= '0;
      r_dopp    <= '0;
      r_thr     <= '0;
      r_detect  <= 1'b0;
      r_len_err <= 1'b0;
    end else if (w_acc) begin
      r_first <= 1'b0;
      r_cnt   <= (r_cnt == LAST_CODE) ? '0 : r_cnt + 1'b1;
      if (r_first) r_thr <= i_threshold;
      if (w_upd) begin
        r_peak <= i_s_axis_tdata;
        r_code <= r_cnt;
        r_dopp <= i_s_axis_tuser;
      end
      if (i_s_axis_tlast) begin
        r_detect  <= (w_peak_new > w_thr);
        r_len_err <= (r_cnt != LAST_CODE);
      end
    end else if (w_out_hs) begin
      r_first <= 1'b1;
      r_cnt   <= '0;
    end
  end

  assign o_s_axis_tready = r_tready;
  assign o_m_valid       = r_m_valid;
  assign o_peak_mag      = r_peak;
  assign o_peak_code     = r_code;
  assign o_peak_dopp     = r_dopp;
  assign o_detect        = r_detect;
  assign o_len_err       = r_len_err;

endmodule
